// File: rtl/flash_rom_loader_pkg.sv
// Shared types and constants for the flash ROM image loader.
package flash_rom_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR0 = 3'd1,
    HDR1 = 3'd2,
    DATA = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_HDR  = 2'd1,
    ERR_OVF  = 2'd2
  } load_err_e;

  localparam logic [15:0] DEFAULT_MAGIC = 16'hC064;

  // States in which the loader is actively consuming the byte stream
  function automatic logic is_load_state(input state_e s);
    return (s == HDR0) || (s == HDR1) || (s == DATA);
  endfunction

endpackage

// File: rtl/flash_rom_loader_if.sv
// Byte-stream, RAM write port and status signals of the ROM image loader.
interface flash_rom_loader_if #(
  parameter int unsigned ADDR_W = 16
) ();

  logic              start;
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_we;
  logic              mem_ready;
  logic              busy;
  logic              load_done;
  logic [1:0]        load_error;
  logic [7:0]        checksum;
  logic              sys_hold;

  modport master (
    input  start, byte_data, byte_valid, mem_ready,
    output mem_addr, mem_data, mem_we, busy, load_done, load_error, checksum, sys_hold
  );

  modport slave (
    output start, byte_data, byte_valid, mem_ready,
    input  mem_addr, mem_data, mem_we, busy, load_done, load_error, checksum, sys_hold
  );

endinterface

// File: rtl/flash_rom_loader_byte_fifo.sv
// First-word fall-through byte FIFO; a push on a full FIFO is accepted only with a same-cycle pop.
module loader_byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_W'(DEPTH));
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/flash_rom_loader.sv
// Validates the flash image header, copies the payload into ROM RAM and releases the core when done.
module flash_rom_loader
  import flash_rom_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int unsigned       LOAD_BYTES = 16384,
  parameter logic [15:0]       MAGIC      = DEFAULT_MAGIC,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter bit                AUTO_START = 1'b1
) (
  input logic               clk,
  input logic               reset,
  flash_rom_loader_if.master bus
);

  localparam int unsigned      CNT_W    = $clog2(LOAD_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LOAD_BYTES - 1);

  state_e            r_state,      w_state;
  logic              r_auto;
  logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr;
  logic [7:0]        r_mem_data,   w_mem_data;
  logic              r_mem_we,     w_mem_we;
  logic              r_busy,       w_busy;
  logic              r_load_done,  w_load_done;
  load_err_e         r_load_error, w_load_error;
  logic [7:0]        r_checksum,   w_checksum;
  logic              r_sys_hold,   w_sys_hold;
  logic [CNT_W-1:0]  r_count,      w_count;

  logic       w_push, w_pop, w_flush, w_arm;
  logic       w_accept, w_last, w_in_load;
  logic       w_fifo_full, w_fifo_empty;
  logic [7:0] w_fifo_dout;

  loader_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   (bus.byte_data),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_auto       <= AUTO_START;
      r_mem_addr   <= BASE_ADDR;
      r_mem_data   <= '0;
      r_mem_we     <= 1'b0;
      r_busy       <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_error <= ERR_NONE;
      r_checksum   <= '0;
      r_sys_hold   <= 1'b1;
      r_count      <= '0;
    end else begin
      r_state      <= w_state;
      r_auto       <= 1'b0;
      r_mem_addr   <= w_mem_addr;
      r_mem_data   <= w_mem_data;
      r_mem_we     <= w_mem_we;
      r_busy       <= w_busy;
      r_load_done  <= w_load_done;
      r_load_error <= w_load_error;
      r_checksum   <= w_checksum;
      r_sys_hold   <= w_sys_hold;
      r_count      <= w_count;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_mem_addr   = r_mem_addr;
    w_mem_data   = r_mem_data;
    w_mem_we     = r_mem_we;
    w_load_done  = r_load_done;
    w_load_error = r_load_error;
    w_checksum   = r_checksum;
    w_sys_hold   = r_sys_hold;
    w_count      = r_count;
    w_pop        = 1'b0;
    w_flush      = 1'b0;
    w_arm        = 1'b0;
    w_in_load    = is_load_state(r_state);
    w_push       = bus.byte_valid && w_in_load;
    w_accept     = r_mem_we && bus.mem_ready;
    w_last       = w_accept && (r_count == LAST_CNT);

    case (r_state)
      IDLE: w_arm = bus.start || r_auto;
      HDR0: begin
        if (!w_fifo_empty) begin
          w_pop = 1'b1;
          if (w_fifo_dout == MAGIC[15:8]) begin
            w_state = HDR1;
          end else begin
            w_state      = ERR;
            w_load_error = ERR_HDR;
          end
        end
      end
      HDR1: begin
        if (!w_fifo_empty) begin
          w_pop = 1'b1;
          if (w_fifo_dout == MAGIC[7:0]) begin
            w_state = DATA;
          end else begin
            w_state      = ERR;
            w_load_error = ERR_HDR;
          end
        end
      end
      DATA: begin
        if (w_accept) begin
          w_mem_addr = r_mem_addr + ADDR_W'(1);
          w_count    = r_count + CNT_W'(1);
          w_checksum = r_checksum + r_mem_data;
          w_mem_we   = 1'b0;
        end
        if (w_last) begin
          w_state     = DONE;
          w_load_done = 1'b1;
          w_sys_hold  = 1'b0;
        end else if (!w_fifo_empty && (!r_mem_we || w_accept)) begin
          // Issue the next write right behind an accepted one for back-to-back throughput
          w_pop      = 1'b1;
          w_mem_we   = 1'b1;
          w_mem_data = w_fifo_dout;
        end
      end
      DONE, ERR: w_arm = bus.start;
      default: w_state = IDLE;
    endcase

    if (w_in_load && bus.byte_valid && w_fifo_full && !w_pop && !w_last) begin
      w_state      = ERR;
      w_load_error = ERR_OVF;
    end

    // Arming flushes the FIFO, which takes priority over any byte arriving this cycle
    if (w_arm) begin
      w_state      = HDR0;
      w_flush      = 1'b1;
      w_mem_addr   = BASE_ADDR;
      w_mem_we     = 1'b0;
      w_checksum   = '0;
      w_load_error = ERR_NONE;
      w_load_done  = 1'b0;
      w_sys_hold   = 1'b1;
      w_count      = '0;
    end

    if (w_state == ERR) w_mem_we = 1'b0;
    w_busy = is_load_state(w_state);
  end

  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_data   = r_mem_data;
  assign bus.mem_we     = r_mem_we;
  assign bus.busy       = r_busy;
  assign bus.load_done  = r_load_done;
  assign bus.load_error = 2'(r_load_error);
  assign bus.checksum   = r_checksum;
  assign bus.sys_hold   = r_sys_hold;

endmodule

// File: tb/tb_flash_rom_loader.sv
// Self-checking bench for flash_rom_loader with a 4-byte payload image.
module tb_flash_rom_loader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  flash_rom_loader_if #(.ADDR_W(16)) bus ();

  flash_rom_loader #(
    .ADDR_W     (16),
    .BASE_ADDR  (16'h0000),
    .LOAD_BYTES (4),
    .MAGIC      (16'hC064),
    .FIFO_DEPTH (4),
    .AUTO_START (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [47:0] bytes;
    logic [1:0]  exp_err;
    logic        exp_done;
    logic [7:0]  exp_cks;
    int          exp_nwr;
  } vec_t;

  vec_t        vecs [6];
  int          total = 0;
  int          bad = 0;
  logic [15:0] acc_addr [$];
  logic [7:0]  acc_data [$];
  int          we_cycles;
  logic        prev_stall;
  logic [15:0] prev_addr;
  logic [7:0]  prev_data;
  bit          rnd_ready;
  int          lowrun;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Records accepted writes and checks the write port is frozen while stalled
  task automatic monitor();
    if (reset) begin
      prev_stall = 1'b0;
      return;
    end
    if (bus.mem_we) we_cycles++;
    if (prev_stall && bus.mem_we) begin
      chk("stall_addr", 32'(bus.mem_addr), 32'(prev_addr));
      chk("stall_data", 32'(bus.mem_data), 32'(prev_data));
    end
    if (bus.mem_we && bus.mem_ready) begin
      acc_addr.push_back(bus.mem_addr);
      acc_data.push_back(bus.mem_data);
    end
    prev_stall = bus.mem_we && !bus.mem_ready;
    prev_addr  = bus.mem_addr;
    prev_data  = bus.mem_data;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #2;
    if (rnd_ready) begin
      if (lowrun >= 2) begin
        bus.mem_ready = 1'b1;
        lowrun = 0;
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
        lowrun = bus.mem_ready ? 0 : lowrun + 1;
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    tick();
    bus.byte_valid = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic clear_mon();
    acc_addr.delete();
    acc_data.delete();
    we_cycles = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
    clear_mon();
    tick();
  endtask

  task automatic rearm();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    clear_mon();
  endtask

  task automatic wait_end(input string name, input int budget);
    int n = 0;
    while (!bus.load_done && bus.load_error == 2'd0 && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_in_budget"}, 32'(n < budget), 32'd1);
  endtask

  task automatic set_vec(input int i, input logic [47:0] b, input logic [1:0] e,
                         input logic d, input logic [7:0] c, input int n);
    vecs[i].bytes    = b;
    vecs[i].exp_err  = e;
    vecs[i].exp_done = d;
    vecs[i].exp_cks  = c;
    vecs[i].exp_nwr  = n;
  endtask

  initial begin
    logic [7:0] pl [4];
    logic [7:0] sum;
    int         nacc;

    reset = 1'b1;
    bus.start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    bus.mem_ready = 1'b1;
    rnd_ready = 1'b0;
    lowrun = 0;
    prev_stall = 1'b0;
    clear_mon();

    set_vec(0, 48'hC0_64_01_02_03_FF, 2'd0, 1'b1, 8'h05, 4);
    set_vec(1, 48'hC0_65_01_02_03_04, 2'd1, 1'b0, 8'h00, 0);
    set_vec(2, 48'h00_64_01_02_03_04, 2'd1, 1'b0, 8'h00, 0);
    set_vec(3, 48'hC0_64_FF_FF_FF_FF, 2'd0, 1'b1, 8'hFC, 4);
    set_vec(4, 48'hC0_64_80_80_10_20, 2'd0, 1'b1, 8'h30, 4);
    set_vec(5, 48'hC0_64_00_00_00_00, 2'd0, 1'b1, 8'h00, 4);

    repeat (2) tick();
    chk("rst_addr",  32'(bus.mem_addr),   32'h0);
    chk("rst_we",    32'(bus.mem_we),     32'h0);
    chk("rst_busy",  32'(bus.busy),       32'h0);
    chk("rst_done",  32'(bus.load_done),  32'h0);
    chk("rst_err",   32'(bus.load_error), 32'h0);
    chk("rst_cks",   32'(bus.checksum),   32'h0);
    chk("rst_hold",  32'(bus.sys_hold),   32'h1);
    reset = 1'b0;
    clear_mon();
    tick();
    chk("auto_start_busy", 32'(bus.busy), 32'h1);

    // Table of whole images, fed with relaxed byte spacing and a ready RAM
    for (int v = 0; v < 6; v++) begin
      do_reset();
      bus.mem_ready = 1'b1;
      for (int k = 0; k < 6; k++) send(vecs[v].bytes[47 - 8*k -: 8], 3);
      wait_end("vec_end", 60);
      repeat (3) tick();
      chk("vec_err",  32'(bus.load_error), 32'(vecs[v].exp_err));
      chk("vec_done", 32'(bus.load_done),  32'(vecs[v].exp_done));
      chk("vec_cks",  32'(bus.checksum),   32'(vecs[v].exp_cks));
      chk("vec_hold", 32'(bus.sys_hold),   32'(!vecs[v].exp_done));
      chk("vec_busy", 32'(bus.busy),       32'h0);
      chk("vec_nwr",  32'(acc_addr.size()), 32'(vecs[v].exp_nwr));
      chk("vec_wecyc", 32'(we_cycles),     32'(vecs[v].exp_nwr));
      for (int i = 0; i < acc_addr.size(); i++) begin
        chk("vec_waddr", 32'(acc_addr[i]), 32'(i));
        chk("vec_wdata", 32'(acc_data[i]), 32'(vecs[v].bytes[31 - 8*i -: 8]));
      end
    end

    // Latency and backpressure on the first payload write
    do_reset();
    bus.mem_ready = 1'b0;
    send(8'hC0, 2);
    send(8'h64, 2);
    bus.byte_data = 8'h11;
    bus.byte_valid = 1'b1;
    tick();
    bus.byte_valid = 1'b0;
    chk("lat_n1_we", 32'(bus.mem_we), 32'h0);
    tick();
    chk("lat_n2_we", 32'(bus.mem_we), 32'h1);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("bp_we",   32'(bus.mem_we),   32'h1);
      chk("bp_addr", 32'(bus.mem_addr), 32'h0);
      chk("bp_data", 32'(bus.mem_data), 32'h11);
    end
    bus.mem_ready = 1'b1;
    tick();
    chk("bp_acc_we",   32'(bus.mem_we),   32'h0);
    chk("bp_acc_addr", 32'(bus.mem_addr), 32'h1);
    chk("bp_acc_cks",  32'(bus.checksum), 32'h11);
    send(8'h22, 8);
    send(8'h33, 8);
    send(8'h44, 8);
    wait_end("bp_end", 60);
    tick();
    chk("bp_done", 32'(bus.load_done), 32'h1);
    chk("bp_cks",  32'(bus.checksum),  32'hAA);
    chk("bp_nwr",  32'(acc_addr.size()), 32'd4);
    chk("bp_last_addr", 32'(acc_addr[3]), 32'h3);
    chk("bp_last_data", 32'(acc_data[3]), 32'h44);

    // Bytes after completion are ignored
    nacc = acc_addr.size();
    send(8'h55, 4);
    chk("done_drop_nwr", 32'(acc_addr.size()), 32'(nacc));
    chk("done_drop_cks", 32'(bus.checksum),    32'hAA);
    chk("done_drop_hold", 32'(bus.sys_hold),   32'h0);

    // Re-arm from DONE, with a start pulse mid-payload that must be ignored
    rearm();
    chk("rearm_done", 32'(bus.load_done), 32'h0);
    chk("rearm_hold", 32'(bus.sys_hold),  32'h1);
    chk("rearm_busy", 32'(bus.busy),      32'h1);
    chk("rearm_cks",  32'(bus.checksum),  32'h0);
    chk("rearm_addr", 32'(bus.mem_addr),  32'h0);
    send(8'hC0, 3);
    send(8'h64, 3);
    send(8'h5A, 3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_in_data_busy", 32'(bus.busy), 32'h1);
    send(8'hA5, 3);
    send(8'h01, 3);
    send(8'h02, 3);
    wait_end("rearm_end", 60);
    tick();
    chk("rearm2_done",  32'(bus.load_done), 32'h1);
    chk("rearm2_err",   32'(bus.load_error), 32'h0);
    chk("rearm2_cks",   32'(bus.checksum),  32'h02);
    chk("rearm2_nwr",   32'(acc_addr.size()), 32'd4);
    chk("rearm2_addr0", 32'(acc_addr[0]),   32'h0);

    // Overflow: stalled RAM, payload bytes back to back
    do_reset();
    bus.mem_ready = 1'b0;
    send(8'hC0, 2);
    send(8'h64, 2);
    for (int k = 0; k < 5; k++) send(8'(8'h10 + k), 1);
    chk("ovf_pre_err", 32'(bus.load_error), 32'h0);
    send(8'h20, 1);
    chk("ovf_err",  32'(bus.load_error), 32'h2);
    chk("ovf_we",   32'(bus.mem_we),     32'h0);
    chk("ovf_busy", 32'(bus.busy),       32'h0);
    chk("ovf_hold", 32'(bus.sys_hold),   32'h1);
    tick();
    chk("ovf_we_after", 32'(bus.mem_we),     32'h0);
    chk("ovf_err_held", 32'(bus.load_error), 32'h2);
    bus.mem_ready = 1'b1;

    // Asynchronous reset in the middle of the payload
    do_reset();
    send(8'hC0, 3);
    send(8'h64, 3);
    send(8'h01, 4);
    send(8'h02, 4);
    chk("mid_nwr",  32'(acc_addr.size()), 32'd2);
    chk("mid_addr", 32'(bus.mem_addr),    32'h2);
    reset = 1'b1;
    #1;
    chk("mid_rst_addr", 32'(bus.mem_addr), 32'h0);
    chk("mid_rst_cks",  32'(bus.checksum), 32'h0);
    chk("mid_rst_hold", 32'(bus.sys_hold), 32'h1);
    chk("mid_rst_we",   32'(bus.mem_we),   32'h0);
    chk("mid_rst_busy", 32'(bus.busy),     32'h0);
    tick();
    reset = 1'b0;
    clear_mon();
    tick();
    chk("mid_auto_busy", 32'(bus.busy), 32'h1);
    send(8'hC0, 3);
    send(8'h64, 3);
    for (int k = 0; k < 4; k++) send(8'(8'h03 + k), 3);
    wait_end("mid_end", 60);
    tick();
    chk("mid_reload_done", 32'(bus.load_done), 32'h1);
    chk("mid_reload_cks",  32'(bus.checksum),  32'h12);

    // Random images against a sum/sequence model, with a jittery RAM ready
    rnd_ready = 1'b1;
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 1) == 1) do_reset();
      else rearm();
      sum = 8'h00;
      for (int i = 0; i < 4; i++) begin
        pl[i] = 8'($urandom);
        sum = sum + pl[i];
      end
      send(8'hC0, $urandom_range(4, 8));
      send(8'h64, $urandom_range(4, 8));
      for (int i = 0; i < 4; i++) send(pl[i], $urandom_range(4, 8));
      wait_end("rnd_end", 200);
      tick();
      chk("rnd_done", 32'(bus.load_done),  32'h1);
      chk("rnd_err",  32'(bus.load_error), 32'h0);
      chk("rnd_cks",  32'(bus.checksum),   32'(sum));
      chk("rnd_nwr",  32'(acc_addr.size()), 32'd4);
      for (int i = 0; i < acc_addr.size() && i < 4; i++) begin
        chk("rnd_waddr", 32'(acc_addr[i]), 32'(i));
        chk("rnd_wdata", 32'(acc_data[i]), 32'(pl[i]));
      end
    end
    rnd_ready = 1'b0;
    bus.mem_ready = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
